// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Holds the sequencer state encoding and the 2-bit ALU opcodes.
package alu_seq_pkg;

    localparam int unsigned DEF_W     = 4;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXEC   = 2'b01,
        RESULT = 2'b10
    } seq_state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the three sequencer channels: command in, ALU drive/return,
// result out. slave = sequencer side, master = surrounding environment.
//   cmd_*  : valid/ready command channel (operands + opcode)
//   alu_*  : registered operands/opcode to the ALU, alu_out1 back
//   res_*  : valid/ready result channel (data + opcode tag)
interface alu_op_sequencer_if #(
    parameter int unsigned W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_in1;
    logic [W-1:0] cmd_in2;
    logic [1:0]   cmd_sel;

    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [1:0]   alu_sel;
    logic [W-1:0] alu_out1;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [1:0]   res_sel;

    modport slave (
        input  cmd_valid, cmd_in1, cmd_in2, cmd_sel, alu_out1, res_ready,
        output cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_sel
    );

    modport master (
        output cmd_valid, cmd_in1, cmd_in2, cmd_sel, alu_out1, res_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_sel
    );
endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of DW bits.
//   push/push_data : write request (ignored when full)
//   pop            : read request (ignored when empty)
//   head_c         : entry at the read pointer (combinational)
//   count          : registered occupancy, 0..DEPTH
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_c,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Both qualifiers look only at the pre-edge occupancy.
    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head_c  = mem[rd_ptr];

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the 4-bit ALU: queues commands, drives one at a
// time onto the ALU inputs, captures alu_out1 and offers it downstream.
//   clk, rst_n : clock, async active-low reset
//   bus        : command / ALU / result channels (slave view)
//   busy       : FSM not idle or commands still queued
//   count      : command FIFO occupancy
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned W     = DEF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_op_sequencer_if.slave      bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = 2 * W + 2;

    seq_state_t    state;
    logic [W-1:0]  alu_in1_q;
    logic [W-1:0]  alu_in2_q;
    logic [1:0]    alu_sel_q;
    logic          res_valid_q;
    logic [W-1:0]  res_data_q;
    logic [1:0]    res_sel_q;

    logic          push_c;
    logic          pop_c;
    logic [DW-1:0] head_c;
    logic [1:0]    head_sel_c;
    logic [W-1:0]  head_in1_c;
    logic [W-1:0]  head_in2_c;

    assign bus.cmd_ready = (count != CW'(DEPTH));
    assign push_c        = bus.cmd_valid && bus.cmd_ready;

    // Pop from IDLE, or straight out of RESULT on a completed handshake.
    assign pop_c = (count != '0) &&
                   ((state == IDLE) ||
                    ((state == RESULT) && res_valid_q && bus.res_ready));

    assign {head_sel_c, head_in1_c, head_in2_c} = head_c;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data ({bus.cmd_sel, bus.cmd_in1, bus.cmd_in2}),
        .pop       (pop_c),
        .head_c    (head_c),
        .count     (count)
    );

    // Sequencer FSM with ALU drive and result capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
        end else begin
            // ALU inputs move only on a pop so the ALU stays quiet otherwise.
            if (pop_c) begin
                alu_in1_q <= head_in1_c;
                alu_in2_q <= head_in2_c;
                alu_sel_q <= head_sel_c;
            end
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= bus.alu_out1;
                    res_sel_q   <= alu_sel_q;
                    res_valid_q <= 1'b1;
                    state       <= RESULT;
                end
                RESULT: begin
                    if (res_valid_q && bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= pop_c ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_in1   = alu_in1_q;
    assign bus.alu_in2   = alu_in2_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_sel   = res_sel_q;
    assign busy          = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [2:0] count;
    int         checks;
    int         errors;

    alu_op_sequencer_if #(.W(4)) bif ();

    alu_op_sequencer #(.DEPTH(4), .W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave),
        .busy  (busy),
        .count (count)
    );

    // Behavioural ALU driven by the sequencer's registered outputs.
    always_comb begin
        case (bif.alu_sel)
            OP_AND:  bif.alu_out1 = bif.alu_in1 & bif.alu_in2;
            OP_OR:   bif.alu_out1 = bif.alu_in1 | bif.alu_in2;
            OP_XOR:  bif.alu_out1 = bif.alu_in1 ^ bif.alu_in2;
            default: bif.alu_out1 = ~(bif.alu_in1 ^ bif.alu_in2);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until accepted (bounded).
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        bif.cmd_valid = 1'b1;
        bif.cmd_in1   = a;
        bif.cmd_in2   = b;
        bif.cmd_sel   = s;
        while (!done && n < 30) begin
            done = (bif.cmd_ready === 1'b1);
            tick();
            n++;
        end
        bif.cmd_valid = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
    endtask

    // Wait for a result (bounded), check it, then let one edge pass.
    task automatic wait_res(input string tag, input logic [3:0] d, input logic [1:0] s);
        int n;
        n = 0;
        while (bif.res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(bif.res_valid), 32'd1);
        chk({tag, "_data"},  32'(bif.res_data),  32'(d));
        chk({tag, "_sel"},   32'(bif.res_sel),   32'(s));
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bif.cmd_valid = 1'b0;
        bif.cmd_in1   = '0;
        bif.cmd_in2   = '0;
        bif.cmd_sel   = '0;
        bif.res_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_count",     32'(count),         32'd0);
        chk("rst_res_valid", 32'(bif.res_valid), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_alu_in1",   32'(bif.alu_in1),   32'd0);
        chk("rst_res_data",  32'(bif.res_data),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);

        // Single op: C AND A = 8, valid two edges after acceptance
        bif.res_ready = 1'b1;
        bif.cmd_valid = 1'b1;
        bif.cmd_in1   = 4'hC;
        bif.cmd_in2   = 4'hA;
        bif.cmd_sel   = OP_AND;
        tick();
        bif.cmd_valid = 1'b0;
        chk("single_count1", 32'(count),         32'd1);
        chk("single_nv1",    32'(bif.res_valid), 32'd0);
        tick();
        chk("single_alu_in1", 32'(bif.alu_in1),   32'hC);
        chk("single_alu_in2", 32'(bif.alu_in2),   32'hA);
        chk("single_nv2",     32'(bif.res_valid), 32'd0);
        chk("single_busy",    32'(busy),          32'd1);
        tick();
        chk("single_valid", 32'(bif.res_valid), 32'd1);
        chk("single_data",  32'(bif.res_data),  32'h8);
        chk("single_sel",   32'(bif.res_sel),   32'd0);
        tick();
        chk("single_done_valid", 32'(bif.res_valid), 32'd0);
        chk("single_done_busy",  32'(busy),          32'd0);

        // Back-to-back OR/XOR/XNOR on C/A -> E, 6, 9, one per 2 cycles
        send(4'hC, 4'hA, OP_OR);
        send(4'hC, 4'hA, OP_XOR);
        send(4'hC, 4'hA, OP_XNOR);
        chk("b2b_r1_valid", 32'(bif.res_valid), 32'd1);
        chk("b2b_r1_data",  32'(bif.res_data),  32'hE);
        chk("b2b_r1_sel",   32'(bif.res_sel),   32'd1);
        tick();
        chk("b2b_gap1",     32'(bif.res_valid), 32'd0);
        chk("b2b_alu_sel2", 32'(bif.alu_sel),   32'd2);
        tick();
        chk("b2b_r2_data",  32'(bif.res_data),  32'h6);
        chk("b2b_r2_sel",   32'(bif.res_sel),   32'd2);
        chk("b2b_alu_hold", 32'(bif.alu_sel),   32'd2);
        tick();
        chk("b2b_gap2",     32'(bif.res_valid), 32'd0);
        chk("b2b_alu_sel3", 32'(bif.alu_sel),   32'd3);
        tick();
        chk("b2b_r3_valid", 32'(bif.res_valid), 32'd1);
        chk("b2b_r3_data",  32'(bif.res_data),  32'h9);
        chk("b2b_r3_sel",   32'(bif.res_sel),   32'd3);
        tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);

        // Backpressure: 6 offered, 5 accepted, count stalls at 4
        bif.res_ready = 1'b0;
        send(4'h1, 4'h3, OP_AND);
        send(4'h5, 4'h6, OP_OR);
        send(4'h9, 4'hC, OP_XOR);
        send(4'h3, 4'h5, OP_XNOR);
        send(4'hF, 4'h0, OP_OR);
        bif.cmd_valid = 1'b1;
        bif.cmd_in1   = 4'h2;
        bif.cmd_in2   = 4'h2;
        bif.cmd_sel   = OP_XOR;
        tick();
        tick();
        tick();
        chk("bp_count",     32'(count),         32'd4);
        chk("bp_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        chk("bp_hold_v",    32'(bif.res_valid), 32'd1);
        chk("bp_hold_d",    32'(bif.res_data),  32'h1);
        bif.cmd_valid = 1'b0;
        bif.res_ready = 1'b1;
        wait_res("bp_r0", 4'h1, OP_AND);
        wait_res("bp_r1", 4'h7, OP_OR);
        wait_res("bp_r2", 4'h5, OP_XOR);
        wait_res("bp_r3", 4'h9, OP_XNOR);
        wait_res("bp_r4", 4'hF, OP_OR);
        chk("bp_count_end", 32'(count), 32'd0);
        chk("bp_busy_end",  32'(busy),  32'd0);

        // Full FIFO with a simultaneous pop: push deferred one cycle
        bif.res_ready = 1'b0;
        send(4'h1, 4'h3, OP_AND);
        send(4'h5, 4'h6, OP_OR);
        send(4'h9, 4'hC, OP_XOR);
        send(4'h3, 4'h5, OP_XNOR);
        send(4'hF, 4'h0, OP_OR);
        chk("full_count",     32'(count),         32'd4);
        chk("full_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        chk("full_r0_data",   32'(bif.res_data),  32'h1);
        bif.cmd_valid = 1'b1;
        bif.cmd_in1   = 4'h2;
        bif.cmd_in2   = 4'h2;
        bif.cmd_sel   = OP_XOR;
        bif.res_ready = 1'b1;
        tick();
        chk("full_pop_count", 32'(count),         32'd3);
        chk("full_pop_ready", 32'(bif.cmd_ready), 32'd1);
        tick();
        bif.cmd_valid = 1'b0;
        chk("full_push_count", 32'(count), 32'd4);
        wait_res("full_r1", 4'h7, OP_OR);
        wait_res("full_r2", 4'h5, OP_XOR);
        wait_res("full_r3", 4'h9, OP_XNOR);
        wait_res("full_r4", 4'hF, OP_OR);
        wait_res("full_r5", 4'h0, OP_XOR);
        chk("full_busy_end", 32'(busy), 32'd0);

        // Reset during RESULT with 3 queued
        bif.res_ready = 1'b0;
        send(4'hA, 4'h5, OP_OR);
        send(4'hB, 4'h4, OP_AND);
        send(4'hC, 4'h3, OP_XOR);
        send(4'hD, 4'h2, OP_XNOR);
        chk("mid_count",  32'(count),         32'd3);
        chk("mid_valid",  32'(bif.res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(bif.res_valid), 32'd0);
        chk("arst_data",    32'(bif.res_data),  32'd0);
        chk("arst_sel",     32'(bif.res_sel),   32'd0);
        chk("arst_alu_in1", 32'(bif.alu_in1),   32'd0);
        chk("arst_alu_in2", 32'(bif.alu_in2),   32'd0);
        chk("arst_alu_sel", 32'(bif.alu_sel),   32'd0);
        chk("arst_count",   32'(count),         32'd0);
        chk("arst_busy",    32'(busy),          32'd0);
        tick();
        rst_n         = 1'b1;
        bif.res_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_ready", 32'(bif.cmd_ready), 32'd1);
        chk("post_rst_valid", 32'(bif.res_valid), 32'd0);
        chk("post_rst_count", 32'(count),         32'd0);
        send(4'h6, 4'h3, OP_XOR);
        wait_res("post_rst_r", 4'h5, OP_XOR);

        // Idle hold: ALU inputs frozen at the last popped command
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_alu_in1", 32'(bif.alu_in1), 32'h6);
            chk("idle_alu_in2", 32'(bif.alu_in2), 32'h3);
            chk("idle_alu_sel", 32'(bif.alu_sel), 32'(OP_XOR));
            chk("idle_busy",    32'(busy),        32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-buffering issue stage that sits directly upstream of the 4-bit `alu` and also captures its result. It accepts operand/opcode commands over a valid/ready handshake and queues them in a small FIFO. It drives one command at a time onto the ALU's combinational inputs, registers `out1`, and presents it downstream with a valid/ready handshake. ALU inputs are held stable between operations so the combinational block does not toggle while idle.

## Interface
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `W`, 4, operand/result width (matches ALU)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO can accept (count < DEPTH)
- `cmd_in1`  in  W  operand A
- `cmd_in2`  in  W  operand B
- `cmd_sel`  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 XNOR
- `alu_in1`  out  W  registered operand A to ALU
- `alu_in2`  out  W  registered operand B to ALU
- `alu_sel`  out  2  registered opcode to ALU
- `alu_out1`  in  W  ALU combinational result
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accepts result
- `res_data`  out  W  captured result
- `res_sel`  out  2  opcode tag of `res_data`
- `busy`  out  1  state ≠ IDLE or FIFO non-empty
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset: FIFO empty, `count`=0, state IDLE. `alu_in1`/`alu_in2`/`alu_sel`/`res_data`/`res_sel` = 0, `res_valid`=0, `busy`=0. `cmd_ready`=1 once reset releases.
- Push happens when `cmd_valid && cmd_ready`. `cmd_ready` derives from the pre-edge `count` only. When full, no push occurs even if a pop happens in the same cycle.
- Pop happens only when the pre-edge `count` > 0. There is no bypass: a command pushed into an empty FIFO cannot be popped on the same edge.
- Simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop, load the `alu_*` registers, go to EXEC.
  - EXEC: ALU settles. On the next edge, capture `alu_out1`→`res_data` and `alu_sel`→`res_sel`, set `res_valid`=1, go to RESULT.
  - RESULT: hold `res_*` stable until `res_valid && res_ready`. On that edge, clear `res_valid`. If the FIFO is non-empty, pop and go to EXEC; otherwise go to IDLE.
- `alu_*` registers change only on a pop. They retain their last values in IDLE and RESULT.
- The width rule is bitwise only: no carries, and results are exactly W bits.
- Reset asserted mid-operation aborts immediately: queued commands are discarded, in-flight results are dropped, and all outputs return to reset values asynchronously.

## Timing
- Command accepted at edge t → popped at edge t+1 (if IDLE) → `res_valid` high after edge t+2.
- Minimum latency from acceptance to valid result is 2 cycles.
- With `res_ready` held high, sustained throughput is one result per 2 cycles.
- The `res_valid` → `res_ready` handshake may complete in the same cycle `res_valid` rises.
- While `res_ready`=0, `res_data`/`res_sel`/`res_valid` hold for any duration.
- Backpressure capacity is DEPTH queued commands plus 1 held in RESULT.

## Structure
- Package `alu_seq_pkg` holds the state enum (IDLE, EXEC, RESULT) and the opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11.
- Sub-module `alu_cmd_fifo` is a synchronous DEPTH×(2W+2) FIFO with push/pop/count and the same `clk`/`rst_n`.
- The top level contains the FSM, the `alu_*` registers and the result registers. The `alu` is instantiated by the parent, not inside this block.

## Test plan
- Single op: in1=4'hC, in2=4'hA, sel=00 with `res_ready`=1 → `res_data`=4'h8 and `res_sel`=00, `res_valid` high 2 cycles after acceptance.
- All opcodes back-to-back on C/A: sel 01/10/11 → 4'hE, 4'h6, 4'h9 in order. Results arrive one per 2 cycles. `alu_*` are stable between pops.
- Backpressure: `res_ready`=0, offer 6 commands → 5 accepted (`count` reaches 4, `cmd_ready`=0). Then raise `res_ready` → 5 results in order and `count` returns to 0.
- Full with simultaneous pop: FIFO full, `cmd_valid`=1, a result handshake occurs → no push that cycle, `count` drops to 3, and the push occurs on the next cycle.
- Reset mid-op: assert `rst_n`=0 during RESULT with 3 queued → all outputs 0 immediately, `count`=0. After release, a new command yields the correct result with no stale data.
- Idle hold: after the last result, leave `cmd_valid`=0 for 10 cycles → `alu_in1`/`alu_in2`/`alu_sel` do not toggle and `busy`=0.
